// File: rtl/perf_pkg.sv
// Shared types and default widths for the performance monitor.
package perf_pkg;

  localparam int CNT_W_DEF = 32;
  localparam int INF_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } perf_state_t;

  typedef enum logic [1:0] {
    D_IDLE,
    D_LOAD,
    D_ITER,
    D_DONE
  } div_state_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle.
// Operands are captured on the start edge, expanded on the load edge,
// iterated W times, then presented for one cycle in D_DONE (done pulse).
// A zero divisor yields a zero quotient.
module seq_divider
  import perf_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient
);

  localparam int CW = $clog2(W + 1);

  div_state_t    state_q, state_d;
  logic [W-1:0]  dvd_q, dvd_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W:0]    rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W:0]    rem_sh;
  logic [W:0]    diff;

  assign busy     = (state_q != D_IDLE);
  assign done     = (state_q == D_DONE);
  assign quotient = (dvs_q == '0) ? '0 : quo_q;

  // Next-state and datapath: shift-subtract with a down-counting iteration timer.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    rem_sh  = {rem_q[W-1:0], quo_q[W-1]};
    diff    = rem_sh - {1'b0, dvs_q};
    unique case (state_q)
      D_IDLE: begin
        if (start) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          state_d = D_LOAD;
        end
      end
      D_LOAD: begin
        rem_d   = '0;
        quo_d   = dvd_q;
        cnt_d   = CW'(W);
        state_d = D_ITER;
      end
      D_ITER: begin
        // diff[W] set means the trial subtraction borrowed: restore.
        if (!diff[W]) begin
          rem_d = diff;
          quo_d = {quo_q[W-2:0], 1'b1};
        end else begin
          rem_d = rem_sh;
          quo_d = {quo_q[W-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = D_DONE;
      end
      D_DONE: state_d = D_IDLE;
      default: state_d = D_IDLE;
    endcase
    // Abort wins over any in-flight work; a simultaneous start restarts cleanly.
    if (abort) begin
      state_d = D_IDLE;
      if (start) begin
        dvd_d   = dividend;
        dvs_d   = divisor;
        state_d = D_LOAD;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= D_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/perf_monitor.sv
// Cycle / retired-instruction counters with a continuously refreshed CPI.
//
//   state  | meaning
//   IDLE   | waiting for the first start_instr; counters held
//   RUN    | counting cycles and retires; CPI refreshed whenever divider is free
//   HALTED | counters frozen; final CPI computed once, then done stays high
module perf_monitor
  import perf_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int INF_W = INF_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             start_instr,
  input  logic             end_instr,
  input  logic             halt,
  output logic [CNT_W-1:0] total_cycles,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cpi,
  output logic             cpi_valid,
  output logic             done,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [INF_W-1:0] INF_MAX = '1;

  perf_state_t      state_q, state_d;
  logic [CNT_W-1:0] tc_q, tc_d;
  logic [CNT_W-1:0] ic_q, ic_d;
  logic [INF_W-1:0] inf_q, inf_d;
  logic [CNT_W-1:0] cpi_q, cpi_d;
  logic             cpi_valid_q, cpi_valid_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             end_ok, start_ok;
  logic [CNT_W-1:0] tc_inc, ic_inc;
  logic             div_start, div_abort, div_busy, div_done;
  logic [CNT_W-1:0] div_quot;

  // A retire needs something in flight; a start at full occupancy is only
  // allowed when a retire frees a slot on the same edge.
  assign end_ok   = end_instr && (inf_q != '0);
  assign start_ok = start_instr && ((inf_q != INF_MAX) || end_ok);
  assign tc_inc   = (tc_q == CNT_MAX) ? tc_q : tc_q + CNT_W'(1);
  assign ic_inc   = (ic_q == CNT_MAX) ? ic_q : ic_q + CNT_W'(1);

  // Snapshot uses next-edge counter values so the halt edge divides frozen totals.
  seq_divider #(.W(CNT_W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .abort    (div_abort),
    .dividend (tc_d),
    .divisor  (ic_d),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quot)
  );

  // FSM, counters, protocol checking and divider sequencing.
  always_comb begin
    state_d     = state_q;
    tc_d        = tc_q;
    ic_d        = ic_q;
    inf_d       = inf_q;
    cpi_d       = cpi_q;
    cpi_valid_d = 1'b0;
    done_d      = done_q;
    err_d       = err_q;
    div_start   = 1'b0;
    div_abort   = 1'b0;
    if (div_done) begin
      cpi_d       = div_quot;
      cpi_valid_d = 1'b1;
      if (state_q == HALTED) done_d = 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (start_instr) begin
          state_d = RUN;
          tc_d    = CNT_W'(1);
          inf_d   = INF_W'(1);
        end
      end
      RUN: begin
        tc_d  = tc_inc;
        if (end_ok) ic_d = ic_inc;
        inf_d = inf_q + INF_W'(start_ok) - INF_W'(end_ok);
        if ((end_instr && (inf_q == '0)) || (start_instr && !start_ok)) err_d = 1'b1;
        if (halt) begin
          state_d   = HALTED;
          div_abort = 1'b1;
          div_start = (ic_d != '0);
        end else begin
          div_start = !div_busy && (ic_d != '0);
        end
      end
      HALTED: begin
        // Nothing retired: no division is started, CPI finalises as zero.
        if (!done_q && !div_busy && (ic_q == '0)) begin
          done_d      = 1'b1;
          cpi_d       = '0;
          cpi_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d     = IDLE;
      tc_d        = '0;
      ic_d        = '0;
      inf_d       = '0;
      cpi_d       = '0;
      cpi_valid_d = 1'b0;
      done_d      = 1'b0;
      err_d       = 1'b0;
      div_start   = 1'b0;
      div_abort   = 1'b1;
    end
  end

  // All monitor state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tc_q        <= '0;
      ic_q        <= '0;
      inf_q       <= '0;
      cpi_q       <= '0;
      cpi_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tc_q        <= tc_d;
      ic_q        <= ic_d;
      inf_q       <= inf_d;
      cpi_q       <= cpi_d;
      cpi_valid_q <= cpi_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign total_cycles = tc_q;
  assign instr_count  = ic_q;
  assign cpi          = cpi_q;
  assign cpi_valid    = cpi_valid_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_perf_monitor.sv
// Self-checking bench for perf_monitor: 32-bit instance for CPI behaviour,
// 8-bit instance sharing the same stimulus for saturation.
module tb_perf_monitor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic start_instr = 1'b0;
  logic end_instr = 1'b0;
  logic halt = 1'b0;

  logic [31:0] total_cycles, instr_count, cpi;
  logic        cpi_valid, done, err;
  logic [7:0]  tc8, ic8, cpi8;
  logic        cpi_valid8, done8, err8;

  typedef struct {
    logic [31:0] tc;
    logic [31:0] ic;
    logic [31:0] cpi;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   valid_cnt = 0;

  perf_monitor #(.CNT_W(32), .INF_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .start_instr(start_instr),
    .end_instr(end_instr), .halt(halt), .total_cycles(total_cycles),
    .instr_count(instr_count), .cpi(cpi), .cpi_valid(cpi_valid),
    .done(done), .err(err)
  );

  perf_monitor #(.CNT_W(8), .INF_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .start_instr(start_instr),
    .end_instr(end_instr), .halt(halt), .total_cycles(tc8),
    .instr_count(ic8), .cpi(cpi8), .cpi_valid(cpi_valid8),
    .done(done8), .err(err8)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (cpi_valid === 1'b1) valid_cnt++;

  task automatic step(input logic s, input logic e, input logic h);
    start_instr = s;
    end_instr   = e;
    halt        = h;
    @(posedge clk);
    #1;
    start_instr = 1'b0;
    end_instr   = 1'b0;
    halt        = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (cpi_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if ({total_cycles, instr_count, cpi} !== 96'd0) begin
      failures++;
      $display("FAIL reset_counters: got tc=%0d ic=%0d cpi=%0d expected 0", total_cycles, instr_count, cpi);
    end
    checks++;
    if ({cpi_valid, done, err} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 000", {cpi_valid, done, err});
    end
    checks++;
    if ({tc8, ic8, cpi8, cpi_valid8, done8, err8} !== 27'd0) begin
      failures++;
      $display("FAIL reset_dut8: got tc=%0d expected 0", tc8);
    end
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (total_cycles !== 32'd0) begin
      failures++;
      $display("FAIL reset_idle: got tc=%0d expected 0", total_cycles);
    end
  endtask

  task automatic test_steady_cpi4();
    exp_t e;
    bit   ok;
    int   v0;
    do_clear();
    exp_q.push_back('{tc: 32'd40, ic: 32'd10, cpi: 32'd4});
    v0 = valid_cnt;
    for (int k = 1; k <= 40; k++)
      step((k % 4) == 1, (k % 4) == 0, k == 40);
    checks++;
    if (valid_cnt == v0) begin
      failures++;
      $display("FAIL cpi4_refresh: got %0d cpi_valid pulses during run expected >0", valid_cnt - v0);
    end
    wait_done(34, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL cpi4_done_latency: got done=%b after 34 edges expected 1", done);
    end
    e = exp_q.pop_front();
    checks++;
    if (total_cycles !== e.tc) begin
      failures++;
      $display("FAIL cpi4_tc: got %0d expected %0d", total_cycles, e.tc);
    end
    checks++;
    if (instr_count !== e.ic) begin
      failures++;
      $display("FAIL cpi4_ic: got %0d expected %0d", instr_count, e.ic);
    end
    checks++;
    if (cpi !== e.cpi) begin
      failures++;
      $display("FAIL cpi4_cpi: got %0d expected %0d", cpi, e.cpi);
    end
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL cpi4_err: got %b expected 0", err);
    end
  endtask

  task automatic test_truncation();
    exp_t e;
    bit   ok;
    do_clear();
    exp_q.push_back('{tc: 32'd45, ic: 32'd10, cpi: 32'd4});
    for (int k = 1; k <= 45; k++)
      step(((k % 4) == 1) && (k <= 37), ((k % 4) == 0) && (k <= 40), k == 45);
    wait_done(34, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || total_cycles !== e.tc || instr_count !== e.ic || cpi !== e.cpi) begin
      failures++;
      $display("FAIL trunc_45_10: got done=%b tc=%0d ic=%0d cpi=%0d expected done=1 tc=%0d ic=%0d cpi=%0d",
               done, total_cycles, instr_count, cpi, e.tc, e.ic, e.cpi);
    end
    do_clear();
    exp_q.push_back('{tc: 32'd7, ic: 32'd2, cpi: 32'd3});
    for (int k = 1; k <= 7; k++)
      step((k == 1) || (k == 3), (k == 2) || (k == 7), k == 7);
    wait_done(34, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || total_cycles !== e.tc || instr_count !== e.ic || cpi !== e.cpi) begin
      failures++;
      $display("FAIL trunc_7_2: got done=%b tc=%0d ic=%0d cpi=%0d expected done=1 tc=%0d ic=%0d cpi=%0d",
               done, total_cycles, instr_count, cpi, e.tc, e.ic, e.cpi);
    end
  endtask

  task automatic test_zero_instr();
    exp_t e;
    do_clear();
    exp_q.push_back('{tc: 32'd20, ic: 32'd0, cpi: 32'd0});
    for (int k = 1; k <= 20; k++)
      step(k == 1, 1'b0, k == 20);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL zero_done_early: got done=%b on halt edge expected 0", done);
    end
    step(1'b0, 1'b0, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL zero_done: got done=%b expected 1", done);
    end
    checks++;
    if (total_cycles !== e.tc || instr_count !== e.ic || cpi !== e.cpi) begin
      failures++;
      $display("FAIL zero_values: got tc=%0d ic=%0d cpi=%0d expected tc=%0d ic=%0d cpi=%0d",
               total_cycles, instr_count, cpi, e.tc, e.ic, e.cpi);
    end
  endtask

  task automatic test_protocol();
    exp_t e;
    bit   ok;
    do_clear();
    exp_q.push_back('{tc: 32'd5, ic: 32'd2, cpi: 32'd2});
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (instr_count !== 32'd1 || err !== 1'b0) begin
      failures++;
      $display("FAIL proto_simul: got ic=%0d err=%b expected ic=1 err=0", instr_count, err);
    end
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (instr_count !== 32'd2 || err !== 1'b0) begin
      failures++;
      $display("FAIL proto_retire: got ic=%0d err=%b expected ic=2 err=0", instr_count, err);
    end
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (instr_count !== 32'd2 || err !== 1'b1) begin
      failures++;
      $display("FAIL proto_underflow: got ic=%0d err=%b expected ic=2 err=1", instr_count, err);
    end
    step(1'b0, 1'b0, 1'b1);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL proto_err_sticky: got err=%b expected 1", err);
    end
    wait_done(34, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || total_cycles !== e.tc || instr_count !== e.ic || cpi !== e.cpi) begin
      failures++;
      $display("FAIL proto_final: got done=%b tc=%0d ic=%0d cpi=%0d expected done=1 tc=%0d ic=%0d cpi=%0d",
               done, total_cycles, instr_count, cpi, e.tc, e.ic, e.cpi);
    end
  endtask

  task automatic test_inflight_overflow();
    do_clear();
    for (int k = 0; k < 15; k++) step(1'b1, 1'b0, 1'b0);
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL ovf_at_max: got err=%b expected 0", err);
    end
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL ovf_err: got err=%b expected 1", err);
    end
    for (int k = 0; k < 16; k++) step(1'b0, 1'b1, 1'b0);
    checks++;
    if (instr_count !== 32'd15) begin
      failures++;
      $display("FAIL ovf_retires: got ic=%0d expected 15", instr_count);
    end
  endtask

  task automatic test_saturation();
    do_clear();
    for (int k = 1; k <= 300; k++) step(k == 1, 1'b0, 1'b0);
    checks++;
    if (tc8 !== 8'd255) begin
      failures++;
      $display("FAIL sat_tc8: got %0d expected 255", tc8);
    end
    checks++;
    if (total_cycles !== 32'd300) begin
      failures++;
      $display("FAIL sat_tc32: got %0d expected 300", total_cycles);
    end
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (tc8 !== 8'd255 || done8 !== 1'b1) begin
      failures++;
      $display("FAIL sat_halt8: got tc=%0d done=%b expected tc=255 done=1", tc8, done8);
    end
  endtask

  task automatic test_clear_abort();
    bit ok;
    int v0;
    do_clear();
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    wait_valid(60, ok);
    checks++;
    if (!ok || cpi !== total_cycles - 32'd34) begin
      failures++;
      $display("FAIL clr_first_cpi: got valid=%b cpi=%0d expected valid=1 cpi=%0d", ok, cpi, total_cycles - 32'd34);
    end
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    checks++;
    if ({total_cycles, instr_count, cpi, cpi_valid, done, err} !== 99'd0) begin
      failures++;
      $display("FAIL clr_outputs: got tc=%0d ic=%0d cpi=%0d flags=%b expected all 0",
               total_cycles, instr_count, cpi, {cpi_valid, done, err});
    end
    v0 = valid_cnt;
    for (int k = 0; k < 40; k++) step(1'b0, 1'b0, 1'b0);
    checks++;
    if (valid_cnt != v0 || cpi !== 32'd0) begin
      failures++;
      $display("FAIL clr_no_valid: got %0d pulses cpi=%0d expected 0 pulses cpi=0", valid_cnt - v0, cpi);
    end
  endtask

  task automatic test_reset_abort();
    bit ok;
    int v0;
    do_clear();
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    wait_valid(60, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rst_first_valid: got valid=%b expected 1", ok);
    end
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({total_cycles, instr_count, cpi, cpi_valid, done, err} !== 99'd0) begin
      failures++;
      $display("FAIL rst_async_outputs: got tc=%0d ic=%0d cpi=%0d flags=%b expected all 0",
               total_cycles, instr_count, cpi, {cpi_valid, done, err});
    end
    v0 = valid_cnt;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) step(1'b0, 1'b0, 1'b0);
    checks++;
    if (valid_cnt != v0 || total_cycles !== 32'd0) begin
      failures++;
      $display("FAIL rst_no_valid: got %0d pulses tc=%0d expected 0 pulses tc=0", valid_cnt - v0, total_cycles);
    end
  endtask

  initial begin
    test_reset();
    test_steady_cpi4();
    test_truncation();
    test_zero_instr();
    test_protocol();
    test_inflight_overflow();
    test_saturation();
    test_clear_abort();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion by 2000000 expected earlier finish");
    $fatal(1, "watchdog expired");
  end

endmodule
